// File: rtl/imem_line_responder_pkg.sv
// imem_line_responder_pkg: line geometry, address split and FSM encoding shared with the cache controller
package imem_line_responder_pkg;
  localparam int LINE_BYTES      = 32;
  localparam int WORDS_PER_LINE  = 8;
  localparam int OFFSET_BITS     = 5;
  localparam int WORD_OFFSET_LSB = 2;
  localparam int WORD_SEL_BITS   = OFFSET_BITS - WORD_OFFSET_LSB;
  localparam int LINE_ADDR_W     = 32 - OFFSET_BITS;
  localparam int WORD_ADDR_W     = 32 - WORD_OFFSET_LSB;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    RESP  = 2'd3
  } state_t;

  // word index of word k within the line whose base is line_base
  function automatic logic [WORD_ADDR_W-1:0] word_index(input logic [LINE_ADDR_W-1:0] line_base,
                                                        input logic [WORD_SEL_BITS-1:0] k);
    return {line_base, k};
  endfunction
endpackage

// File: rtl/imem_line_responder_word_ram.sv
// imem_word_ram: simple dual-port word store, one write port and one read-first synchronous read port
module imem_word_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];

  // read sees the pre-write contents when both ports hit the same word
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end
endmodule

// File: rtl/imem_line_responder.sv
// imem_line_responder: serves 32-byte line fills from an internal word store after a fixed latency
module imem_line_responder
  import imem_line_responder_pkg::*;
#(
  parameter int LATENCY     = 4,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_req_in,
  input  logic [31:0]  mem_addr_in,
  output logic [255:0] mem_data_out,
  output logic         mem_ready_out,
  input  logic         load_we,
  input  logic [31:0]  load_addr,
  input  logic [31:0]  load_data,
  output logic         busy_out,
  output logic         err_out
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [WORD_ADDR_W-1:0] DEPTH_W = WORD_ADDR_W'(DEPTH_WORDS);

  state_t                   state;
  logic [LINE_ADDR_W-1:0]   base;
  logic [7:0]               cnt;
  logic [3:0]               beat;
  logic                     rd_pend;
  logic                     rd_oor;
  logic                     err_acc;
  logic [2:0]               rd_slice;
  logic [31:0]              rd_data;
  logic [WORD_ADDR_W-1:0]   rd_word;
  logic                     wr_en;
  logic                     unused_offset;

  assign rd_word       = word_index(base, beat[2:0]);
  assign wr_en         = load_we && (load_addr[31:2] < DEPTH_W);
  assign busy_out      = state != IDLE;
  assign unused_offset = ^mem_addr_in[4:0];

  imem_word_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (load_addr[AW+1:2]),
    .wdata (load_data),
    .raddr (rd_word[AW-1:0]),
    .rdata (rd_data)
  );

  // transfer FSM: latch request, count latency, issue 8 reads, capture each one a cycle later, pulse ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      base          <= '0;
      cnt           <= '0;
      beat          <= '0;
      rd_pend       <= 1'b0;
      rd_oor        <= 1'b0;
      rd_slice      <= '0;
      err_acc       <= 1'b0;
      err_out       <= 1'b0;
      mem_ready_out <= 1'b0;
      mem_data_out  <= '0;
    end else begin
      mem_ready_out <= 1'b0;
      rd_pend       <= 1'b0;
      if (rd_pend) begin
        mem_data_out[{rd_slice, 5'b0} +: 32] <= rd_oor ? 32'h0000_0000 : rd_data;
        err_acc <= err_acc | rd_oor;
      end
      case (state)
        IDLE: if (mem_req_in) begin
          base         <= mem_addr_in[31:5];
          mem_data_out <= '0;
          err_out      <= 1'b0;
          err_acc      <= 1'b0;
          beat         <= '0;
          cnt          <= 8'(LATENCY);
          state        <= (LATENCY == 0) ? BURST : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) state <= BURST;
        end
        BURST: if (beat[3]) begin
          state         <= RESP;
          mem_ready_out <= 1'b1;
          err_out       <= err_acc | rd_oor;
        end else begin
          beat     <= beat + 4'd1;
          rd_pend  <= 1'b1;
          rd_slice <= beat[2:0];
          rd_oor   <= rd_word >= DEPTH_W;
        end
        RESP: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_line_responder.sv
// tb_imem_line_responder: randomized scoreboard bench driving a LATENCY=4 and a LATENCY=0 responder in lockstep
module tb_imem_line_responder;
  localparam int DEPTH = 1024;
  localparam int LAT [2] = '{4, 0};

  typedef struct {
    logic [255:0] line;
    logic         err;
    int           cyc;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               mem_req_in = 1'b0;
  logic [31:0]        mem_addr_in = '0;
  logic               load_we = 1'b0;
  logic [31:0]        load_addr = '0;
  logic [31:0]        load_data = '0;
  logic [1:0][255:0]  dat;
  logic [1:0]         rdy, eo, bsy;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [DEPTH];
  exp_t        q [2][$];
  exp_t        mx;
  logic [1:0]  hold_v = '0;
  logic [255:0] hold_d [2];

  imem_line_responder #(.LATENCY(4), .DEPTH_WORDS(DEPTH)) dut4 (
    .clk(clk), .rst_n(rst_n), .mem_req_in(mem_req_in), .mem_addr_in(mem_addr_in),
    .mem_data_out(dat[0]), .mem_ready_out(rdy[0]), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .busy_out(bsy[0]), .err_out(eo[0]));

  imem_line_responder #(.LATENCY(0), .DEPTH_WORDS(DEPTH)) dut0 (
    .clk(clk), .rst_n(rst_n), .mem_req_in(mem_req_in), .mem_addr_in(mem_addr_in),
    .mem_data_out(dat[1]), .mem_ready_out(rdy[1]), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .busy_out(bsy[1]), .err_out(eo[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, act, exp);
    end
  endtask

  // expected line from the reference store: word k of line a/32, zero and flagged when beyond the store
  function automatic exp_t model(input logic [31:0] a, input int lat, input int e);
    exp_t r;
    longint idx;
    r.line = '0;
    r.err  = 1'b0;
    r.cyc  = e + lat + 9;
    for (int k = 0; k < 8; k++) begin
      idx = longint'(a / 32) * 8 + k;
      if (idx < DEPTH) r.line[32*k +: 32] = ref_mem[idx];
      else r.err = 1'b1;
    end
    return r;
  endfunction

  task automatic issue(input logic [31:0] a);
    int e;
    @(negedge clk);
    mem_req_in  = 1'b1;
    mem_addr_in = a;
    e = cyc + 1;
    for (int i = 0; i < 2; i++) q[i].push_back(model(a, LAT[i], e));
    @(negedge clk);
    mem_req_in  = 1'b0;
    mem_addr_in = $urandom;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    load_we   = 1'b1;
    load_addr = a;
    load_data = d;
    if (a[31:2] < DEPTH) ref_mem[a[11:2]] = d;
    @(negedge clk);
    load_we = 1'b0;
  endtask

  task automatic check_quiet(input string n);
    for (int i = 0; i < 2; i++) begin
      chk({n, "_data"}, dat[i], '0);
      chk({n, "_ready"}, 256'(rdy[i]), '0);
      chk({n, "_err"}, 256'(eo[i]), '0);
      chk({n, "_busy"}, 256'(bsy[i]), '0);
    end
  endtask

  // monitor: every ready pulse pops the oldest expectation; afterwards the line must hold while idle
  always @(negedge clk) begin
    if (!rst_n) hold_v = '0;
    else for (int i = 0; i < 2; i++) begin
      if (rdy[i]) begin
        if (q[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready dut%0d at cycle %0d: got pulse expected none", i, cyc);
        end else begin
          mx = q[i].pop_front();
          chk("ready_cycle", 256'(cyc), 256'(mx.cyc));
          chk("line", dat[i], mx.line);
          chk("err_out", 256'(eo[i]), 256'(mx.err));
          chk("busy_at_ready", 256'(bsy[i]), 256'(1));
          hold_v[i] = 1'b1;
          hold_d[i] = mx.line;
        end
      end else if (hold_v[i]) begin
        if (bsy[i]) hold_v[i] = 1'b0;
        else chk("hold", dat[i], hold_d[i]);
      end
    end
  end

  initial begin
    logic [31:0] nw;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;
    for (int w = 0; w < DEPTH; w++) load(32'(w * 4), (w < 8) ? 32'h1000_0000 + 32'(w) : $urandom);
    load(32'h0000_1000, 32'hDEAD_BEEF);

    issue(32'h0000_0014);
    repeat (13) @(negedge clk);
    issue(32'h0000_0020);
    repeat (13) @(negedge clk);

    issue(32'h0000_0100 + ($urandom_range(0, 31) << 5));
    repeat (2) @(negedge clk);
    mem_req_in  = 1'b1;
    mem_addr_in = 32'h0000_0040;
    @(negedge clk);
    mem_req_in  = 1'b0;
    repeat (10) @(negedge clk);
    issue(32'h0000_0060);
    repeat (13) @(negedge clk);

    issue(32'h0000_1000);
    repeat (13) @(negedge clk);
    issue(32'h8000_0000);
    repeat (13) @(negedge clk);
    issue(32'h0000_0040);
    repeat (13) @(negedge clk);

    issue(32'h0000_0000);
    repeat (8) @(negedge clk);
    nw = $urandom;
    load(32'h0000_0008, nw);
    repeat (12) @(negedge clk);
    issue(32'h0000_0000);
    repeat (13) @(negedge clk);

    issue(32'h0000_0080);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    q[0].delete();
    q[1].delete();
    #1;
    check_quiet("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_quiet("after_abort");
    issue(32'h0000_0080);
    repeat (13) @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) load(32'($urandom_range(0, DEPTH - 1)) << 2, $urandom);
      issue(($urandom_range(0, 4) == 0) ? 32'h0000_1000 + $urandom_range(0, 32'h3FF) : $urandom_range(0, 32'hFFF));
      repeat (13 + $urandom_range(0, 6)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    chk("pending_dut4", 256'(q[0].size()), '0);
    chk("pending_dut0", 256'(q[1].size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_line_responder.md
# imem_line_responder

Memory-side responder for the instruction-cache line-fill protocol: accepts a single-cycle line request (request pulse plus 32-bit address), waits a programmable latency, reads the 8 words of the 32-byte line from an internal word RAM over 8 sequential beats, and returns the assembled 256-bit line with a one-cycle ready pulse. It sits between the instruction cache controller's miss port and the instruction backing store. A preload write port lets the testbench or boot logic fill the store.

## Interface
- LATENCY, 4: extra wait cycles between request acceptance and the first RAM beat (0..255).
- DEPTH_WORDS, 1024: backing store depth in 32-bit words (power of two).
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- mem_req_in  input  1  line request pulse from the cache.
- mem_addr_in  input  32  byte address; sampled only with mem_req_in in IDLE; bits [4:0] ignored.
- mem_data_out  output  256  assembled line; word k (byte offset 4k) at bits [32k+31:32k].
- mem_ready_out  output  1  one-cycle pulse: mem_data_out is valid.
- load_we  input  1  preload write enable.
- load_addr  input  32  preload byte address; word index = load_addr[31:2].
- load_data  input  32  preload write data.
- busy_out  output  1  high in every state except IDLE.
- err_out  output  1  high with mem_ready_out when any word of the line was out of range.

## Operation
- States: IDLE, WAIT, BURST, RESP.
- IDLE: if mem_req_in=1, latch line base = mem_addr_in[31:5]; go to WAIT with counter=LATENCY, or to BURST if LATENCY=0.
- WAIT: decrement counter each cycle; on reaching 0, go to BURST. Counter width 8 bits.
- BURST: beat counter 0..7 issues RAM read of word {base,beat[2:0]}; synchronous read data written into mem_data_out slice beat on the following cycle. After the last slice is captured, go to RESP.
- RESP: mem_ready_out=1 for exactly this cycle; then IDLE.
- mem_req_in outside IDLE: ignored, not queued.
- Out of range: word index >= DEPTH_WORDS reads as 32'h0000_0000 (NOP); err_out asserted in RESP if any beat was out of range; cleared at next request acceptance.
- mem_data_out: cleared to 0 at request acceptance, slices filled per beat, held stable from RESP until the next accepted request (the cache samples it one cycle after ready).
- Preload: load_we writes any cycle, any state; out-of-range load addresses are dropped. Same-cycle write and read of one word: read returns old data.
- Reset: all outputs 0, state IDLE, counters 0; reset during WAIT/BURST/RESP aborts the transfer with no ready pulse. RAM contents are not reset.

## Timing
- Request sampled at edge 0; mem_ready_out high from edge LATENCY+9 to edge LATENCY+10 (LATENCY=4: edges 13..14; LATENCY=0: edges 9..10).
- busy_out high from edge 1 through the end of the RESP cycle.
- Earliest next request sampled at edge LATENCY+11.
- No combinational path from any input to any output.

## Structure
- Shared package: LINE_BYTES=32, WORDS_PER_LINE=8, OFFSET_BITS=5, the address-field split constants also used by the cache controller, and the state encoding (IDLE=0, WAIT=1, BURST=2, RESP=3).
- One sub-module: imem_word_ram, a simple dual-port RAM (one write port, one synchronous read-first read port), DEPTH_WORDS x 32.

## Test plan
- Preload words 0..7 with 32'h1000_0000+k; request addr 32'h0000_0014, LATENCY=4 -> ready at edge 13 only, mem_data_out[31:0]=32'h1000_0000, [255:224]=32'h1000_0007, err_out=0.
- LATENCY=0, request addr 32'h0000_0020 -> ready at edge 9, line holds words 8..15; data unchanged for 5 cycles after ready.
- Second mem_req_in pulse at edge 3 of a transfer -> ignored; exactly one ready pulse; a request at edge LATENCY+11 is accepted normally.
- DEPTH_WORDS=1024, request addr 32'h0000_1000 -> line all zeros, err_out=1 with ready; next in-range request clears err_out.
- rst_n low during BURST -> no ready pulse, outputs 0, busy_out=0; request after release completes with correct data.
- load_we writes word 2 while beat 5 is in flight -> new value in line slice 2 only on the next request.
